lut_cfg_loader: RTL

- Serial configuration loader that sits directly upstream of the fabric's 3-input LUTs.
- Accepts a bit-serial configuration stream through a valid/ready handshake and assembles it into a shadow register.
- Commits all LUT truth-table masks atomically, so no LUT ever evaluates a partially loaded mask.
- Output is a flat mask bus; the fabric wrapper slices it into each LUT's 8-entry mask.

---
 rtl/lut_cfg_loader_if.sv | 27 ++
 rtl/lut_cfg_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lut_cfg_loader_if.sv
// Configuration-stream and committed-mask bundle between a loader source and lut_cfg_loader.
// Ports: cfg_start/cfg_valid/cfg_bit go from source to loader; cfg_ready and masks go from loader to source.
//        cfg_busy, cfg_done and cfg_err are loader status back to the source.
// master = stream source / fabric side, slave = the loader itself.
interface lut_cfg_loader_if #(
    parameter int NUM_LUTS = 4,
    parameter int MASK_W   = 8
);
    logic                       cfg_start;
    logic                       cfg_valid;
    logic                       cfg_bit;
    logic                       cfg_ready;
    logic [NUM_LUTS*MASK_W-1:0] masks;
    logic                       cfg_busy;
    logic                       cfg_done;
    logic                       cfg_err;

    modport master (
        output cfg_start, cfg_valid, cfg_bit,
        input  cfg_ready, masks, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit,
        output cfg_ready, masks, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/lut_cfg_loader.sv
// Bit-serial loader that fills a shadow register and commits every LUT truth-table mask in one step.
// Latency: masks and cfg_done update one cycle after the final handshake (single COMMIT cycle).
// Backpressure: cfg_ready is high only in LOAD; cfg_valid gaps of any length are tolerated.
// Ports: clk, rst (sync, active high); bus (slave modport) carries start/valid/bit in and
//        ready/masks/busy/done/err out. masks bit MASK_W*i+j is LUT i mask[j].
// Optional: define LUT_CFG_PARITY_EN to append one even-parity bit per load; a bad parity
//        rejects the load (cfg_err) and leaves masks untouched. Undefined: cfg_err is tied low.
module lut_cfg_loader #(
    parameter int NUM_LUTS = 4,
    parameter int MASK_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    lut_cfg_loader_if.slave   bus
);
    localparam int N     = NUM_LUTS * MASK_W;
    localparam int CNT_W = $clog2(N + 2);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(N - 1);
`ifdef LUT_CFG_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_IDX   = CNT_W'(N);
`endif

    // 3-input LUTs have exactly 8 truth-table entries.
    generate
        if (MASK_W != 8) begin : g_bad_mask_w
            $error("lut_cfg_loader: MASK_W must be 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     shadow;
    logic [N-1:0]     masks_q;
    logic [CNT_W-1:0] cnt;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             xfer;
`ifdef LUT_CFG_PARITY_EN
    logic             par_q;
    logic             err_q;
`endif

    // ready_q is only ever high in LOAD, so this is the handshake.
    assign xfer = bus.cfg_valid && ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shadow  <= '0;
            masks_q <= '0;
            cnt     <= CNT_ZERO;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
            par_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cfg_start) begin
                        state   <= LOAD;
                        cnt     <= CNT_ZERO;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef LUT_CFG_PARITY_EN
                        par_q   <= 1'b0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    // A restart outranks a bit arriving in the same cycle.
                    if (bus.cfg_start) begin
                        cnt   <= CNT_ZERO;
`ifdef LUT_CFG_PARITY_EN
                        par_q <= 1'b0;
`endif
                    end else if (xfer) begin
                        cnt <= cnt + CNT_ONE;
`ifdef LUT_CFG_PARITY_EN
                        if (cnt == PAR_IDX) begin
                            // Trailing parity bit: the running XOR including it must be 0.
                            ready_q <= 1'b0;
                            if (par_q ^ bus.cfg_bit) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                                err_q  <= 1'b1;
                            end else begin
                                state  <= COMMIT;
                            end
                        end else begin
                            shadow[cnt[IDX_W-1:0]] <= bus.cfg_bit;
                            par_q                  <= par_q ^ bus.cfg_bit;
                        end
`else
                        shadow[cnt[IDX_W-1:0]] <= bus.cfg_bit;
                        if (cnt == LAST_DATA) begin
                            state   <= COMMIT;
                            ready_q <= 1'b0;
                        end
`endif
                    end
                end
                COMMIT: begin
                    // cfg_start is deliberately not looked at here.
                    masks_q <= shadow;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready = ready_q;
    assign bus.cfg_busy  = busy_q;
    assign bus.cfg_done  = done_q;
    assign bus.masks     = masks_q;
`ifdef LUT_CFG_PARITY_EN
    assign bus.cfg_err   = err_q;
`else
    assign bus.cfg_err   = 1'b0;
`endif

endmodule
